// File: rtl/rtc_bus_pkg.sv
// Shared constants for the RTC bus responder: register map and BCD wrap limits.
package rtc_bus_pkg;

    localparam logic [7:0] ADDR_CTRL = 8'h00;
    localparam logic [7:0] ADDR_SEC  = 8'h21;
    localparam logic [7:0] ADDR_MIN  = 8'h22;
    localparam logic [7:0] ADDR_HR   = 8'h23;
    localparam logic [7:0] ADDR_DAY  = 8'h24;
    localparam logic [7:0] ADDR_MON  = 8'h25;
    localparam logic [7:0] ADDR_YEAR = 8'h26;
    localparam logic [7:0] ADDR_XFER = 8'hF0;

    localparam logic [7:0] SEC_MIN  = 8'h00;
    localparam logic [7:0] SEC_MAX  = 8'h59;
    localparam logic [7:0] MIN_MIN  = 8'h00;
    localparam logic [7:0] MIN_MAX  = 8'h59;
    localparam logic [7:0] HR_MIN   = 8'h00;
    localparam logic [7:0] HR_MAX   = 8'h23;
    localparam logic [7:0] DAY_MIN  = 8'h01;
    localparam logic [7:0] DAY_MAX  = 8'h31;
    localparam logic [7:0] MON_MIN  = 8'h01;
    localparam logic [7:0] MON_MAX  = 8'h12;
    localparam logic [7:0] YEAR_MIN = 8'h00;
    localparam logic [7:0] YEAR_MAX = 8'h99;

endpackage

// File: rtl/bcd_wrap_inc.sv
// Single BCD register increment with wrap to a minimum and carry out.
module bcd_wrap_inc (
    input  logic [7:0] value,
    input  logic [7:0] min,
    input  logic [7:0] max,
    input  logic       en,
    output logic [7:0] next,
    output logic       carry
);

    always_comb begin
        next  = value;
        carry = 1'b0;
        if (en) begin
            // Out-of-range bytes (e.g. written garbage) also fall into the wrap branch.
            if (value >= max) begin
                next  = min;
                carry = 1'b1;
            end else if (value[3:0] >= 4'd9) begin
                next = {value[7:4] + 4'd1, 4'd0};
            end else begin
                next = value + 8'd1;
            end
        end
    end

endmodule

// File: rtl/rtc_bus_responder.sv
// Responder end of the RTC multiplexed address/data bus with a free-running BCD
// time/date block advanced once per divider period.
module rtc_bus_responder
    import rtc_bus_pkg::*;
#(
    parameter int unsigned TICK_DIV = 100000000
) (
    input  logic       CLK,
    input  logic       reset,
    input  logic       cs_n,
    input  logic       ad_n,
    input  logic       wr_n,
    input  logic       rd_n,
    input  logic [7:0] ADin,
    output logic [7:0] ADout,
    output logic       ad_oe,
    output logic       sec_tick
);

    localparam logic [31:0] DIV_LAST = 32'(TICK_DIV - 1);

    logic        ad_q, wr_q, rd_q;
    logic [7:0]  addr;
    logic        halt;
    logic [31:0] div_cnt;
    logic [7:0]  t_sec, t_min, t_hr, t_day, t_mon, t_year;
    logic [7:0]  sec_nxt, min_nxt, hr_nxt, day_nxt, mon_nxt, year_nxt;
    logic        sec_c, min_c, hr_c, day_c, mon_c, year_carry_unused;
    logic        tick, adv;
    logic        ad_rise, wr_rise, rd_active;
    logic [7:0]  rd_data;

    assign tick = (div_cnt == DIV_LAST);
    assign adv  = tick & ~halt;

    assign ad_rise   = ~ad_q & ad_n & ~cs_n;
    // rd_n must have stayed high into the wr_n release; a joint wr/rd release is a collision.
    assign wr_rise   = ~wr_q & wr_n & ~cs_n & rd_n & rd_q;
    assign rd_active = ~cs_n & ~rd_n & wr_n;

    bcd_wrap_inc u_inc_sec  (.value(t_sec),  .min(SEC_MIN),  .max(SEC_MAX),  .en(adv),   .next(sec_nxt),  .carry(sec_c));
    bcd_wrap_inc u_inc_min  (.value(t_min),  .min(MIN_MIN),  .max(MIN_MAX),  .en(sec_c), .next(min_nxt),  .carry(min_c));
    bcd_wrap_inc u_inc_hr   (.value(t_hr),   .min(HR_MIN),   .max(HR_MAX),   .en(min_c), .next(hr_nxt),   .carry(hr_c));
    bcd_wrap_inc u_inc_day  (.value(t_day),  .min(DAY_MIN),  .max(DAY_MAX),  .en(hr_c),  .next(day_nxt),  .carry(day_c));
    bcd_wrap_inc u_inc_mon  (.value(t_mon),  .min(MON_MIN),  .max(MON_MAX),  .en(day_c), .next(mon_nxt),  .carry(mon_c));
    bcd_wrap_inc u_inc_year (.value(t_year), .min(YEAR_MIN), .max(YEAR_MAX), .en(mon_c), .next(year_nxt), .carry(year_carry_unused));

    always_comb begin
        rd_data = 8'h00;
        case (addr)
            ADDR_CTRL: rd_data = {7'd0, halt};
            ADDR_SEC:  rd_data = t_sec;
            ADDR_MIN:  rd_data = t_min;
            ADDR_HR:   rd_data = t_hr;
            ADDR_DAY:  rd_data = t_day;
            ADDR_MON:  rd_data = t_mon;
            ADDR_YEAR: rd_data = t_year;
            ADDR_XFER: rd_data = 8'h00;
            default:   rd_data = 8'h00;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            ad_q     <= 1'b1;
            wr_q     <= 1'b1;
            rd_q     <= 1'b1;
            addr     <= 8'h00;
            halt     <= 1'b0;
            div_cnt  <= 32'd0;
            sec_tick <= 1'b0;
            t_sec    <= SEC_MIN;
            t_min    <= MIN_MIN;
            t_hr     <= HR_MIN;
            t_day    <= DAY_MIN;
            t_mon    <= MON_MIN;
            t_year   <= YEAR_MIN;
            ADout    <= 8'h00;
            ad_oe    <= 1'b0;
        end else begin
            ad_q <= ad_n;
            wr_q <= wr_n;
            rd_q <= rd_n;

            if (ad_rise)
                addr <= ADin;

            div_cnt  <= tick ? 32'd0 : div_cnt + 32'd1;
            sec_tick <= tick;

            t_sec  <= sec_nxt;
            t_min  <= min_nxt;
            t_hr   <= hr_nxt;
            t_day  <= day_nxt;
            t_mon  <= mon_nxt;
            t_year <= year_nxt;

            // Bus write overrides the tick update of the same register only.
            if (wr_rise) begin
                case (addr)
                    ADDR_CTRL: halt   <= ADin[0];
                    ADDR_SEC:  t_sec  <= ADin;
                    ADDR_MIN:  t_min  <= ADin;
                    ADDR_HR:   t_hr   <= ADin;
                    ADDR_DAY:  t_day  <= ADin;
                    ADDR_MON:  t_mon  <= ADin;
                    ADDR_YEAR: t_year <= ADin;
                    default: ;
                endcase
            end

            if (rd_active) begin
                ADout <= rd_data;
                ad_oe <= 1'b1;
            end else begin
                ad_oe <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_rtc_bus_responder.sv
// Scoreboard bench for rtc_bus_responder against a transaction-level calendar model.
module tb_rtc_bus_responder;

    localparam int TD = 10;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       cs_n = 1'b1, ad_n = 1'b1, wr_n = 1'b1, rd_n = 1'b1;
    logic [7:0] ADin = 8'h00;
    logic [7:0] ADout;
    logic       ad_oe, sec_tick;

    always #5 CLK = ~CLK;

    rtc_bus_responder #(.TICK_DIV(TD)) dut (
        .CLK(CLK), .reset(reset), .cs_n(cs_n), .ad_n(ad_n), .wr_n(wr_n), .rd_n(rd_n),
        .ADin(ADin), .ADout(ADout), .ad_oe(ad_oe), .sec_tick(sec_tick)
    );

    int errors = 0;
    int checks = 0;

    // Reference state: seconds counter position, halt flag, sec..year as bytes.
    int m_cnt = 0;
    bit m_halt = 1'b0;
    int m_t[6] = '{0, 0, 0, 1, 1, 0};
    int lim_lo[6] = '{'h00, 'h00, 'h00, 'h01, 'h01, 'h00};
    int lim_hi[6] = '{'h59, 'h59, 'h23, 'h31, 'h12, 'h99};

    bit rd_active = 1'b0;
    int rd_addr = 0;
    bit wr_pend = 1'b0;
    int wr_addr = 0, wr_data = 0;
    bit exp_oe = 1'b0, exp_tick = 1'b0;
    int exp_q[$];

    function automatic int bcd_step(int v, int lo, int hi);
        if (v >= hi) return lo;
        if ((v % 16) >= 9) return (v / 16 + 1) * 16;
        return v + 1;
    endfunction

    function automatic int model_read(int a);
        if (a == 'h00) return int'(m_halt);
        if (a >= 'h21 && a <= 'h26) return m_t[a - 'h21];
        return 0;
    endfunction

    // Model: one update per clock edge, driven by intent flags posted by the tasks.
    initial forever begin
        int  nt[6];
        bit  carry;
        @(posedge CLK);
        if (reset) begin
            m_cnt = 0;
            m_halt = 1'b0;
            m_t = '{0, 0, 0, 1, 1, 0};
            exp_oe = 1'b0;
            exp_tick = 1'b0;
        end else begin
            exp_oe = rd_active;
            if (rd_active) exp_q.push_back(model_read(rd_addr));
            exp_tick = (m_cnt == TD - 1);
            m_cnt = exp_tick ? 0 : m_cnt + 1;
            nt = m_t;
            if (exp_tick && !m_halt) begin
                carry = 1'b1;
                for (int i = 0; i < 6; i++) begin
                    if (carry) begin
                        nt[i] = bcd_step(m_t[i], lim_lo[i], lim_hi[i]);
                        carry = (m_t[i] >= lim_hi[i]);
                    end
                end
            end
            if (wr_pend) begin
                if (wr_addr == 'h00) m_halt = wr_data[0];
                else if (wr_addr >= 'h21 && wr_addr <= 'h26) nt[wr_addr - 'h21] = wr_data;
                wr_pend = 1'b0;
            end
            m_t = nt;
        end
    end

    // Monitor: per-cycle strobe checks; pop one expected byte whenever the DUT drives the bus.
    initial forever begin
        int e;
        @(negedge CLK);
        checks++;
        if (ad_oe !== exp_oe) begin
            errors++;
            $display("FAIL ad_oe t=%0t got=%b want=%b", $time, ad_oe, exp_oe);
        end
        checks++;
        if (sec_tick !== exp_tick) begin
            errors++;
            $display("FAIL sec_tick t=%0t got=%b want=%b", $time, sec_tick, exp_tick);
        end
        if (ad_oe === 1'b1) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL read_unexpected t=%0t got=%02h want=no read", $time, ADout);
            end else begin
                e = exp_q.pop_front();
                if (ADout !== 8'(e)) begin
                    errors++;
                    $display("FAIL read_data t=%0t got=%02h want=%02h", $time, ADout, 8'(e));
                end
            end
        end
    end

    task automatic addr_phase(input int a);
        @(negedge CLK);
        cs_n = 1'b0; ad_n = 1'b0; ADin = 8'(a);
        @(negedge CLK);
        ad_n = 1'b1;
    endtask

    task automatic write_reg(input int a, input int d, input bit drop_cs = 1'b0);
        addr_phase(a);
        @(negedge CLK);
        ADin = 8'(d); wr_n = 1'b0;
        if (drop_cs) begin
            @(negedge CLK);
            cs_n = 1'b1;
            @(negedge CLK);
            wr_n = 1'b1;
        end else begin
            @(negedge CLK);
            wr_n = 1'b1;
            wr_addr = a; wr_data = d; wr_pend = 1'b1;
        end
        @(negedge CLK);
        cs_n = 1'b1;
    endtask

    // Commits the write on the edge where the divider position equals target.
    task automatic write_timed(input int a, input int d, input int target);
        int n;
        addr_phase(a);
        @(negedge CLK);
        ADin = 8'(d); wr_n = 1'b0;
        @(negedge CLK);
        n = 0;
        while (m_cnt != target && n < 3 * TD) begin
            @(negedge CLK);
            n++;
        end
        checks++;
        if (m_cnt != target) begin
            errors++;
            $display("FAIL timed_write_wait got=%0d want=%0d", m_cnt, target);
        end
        wr_n = 1'b1;
        wr_addr = a; wr_data = d; wr_pend = 1'b1;
        @(negedge CLK);
        cs_n = 1'b1;
    endtask

    task automatic read_reg(input int a);
        addr_phase(a);
        @(negedge CLK);
        rd_n = 1'b0; rd_addr = a; rd_active = 1'b1;
        @(negedge CLK);
        rd_n = 1'b1; rd_active = 1'b0;
        @(negedge CLK);
        cs_n = 1'b1;
    endtask

    task automatic wait_ticks(input int n);
        int seen, c;
        seen = 0; c = 0;
        while (seen < n && c < (n + 1) * TD + 5) begin
            @(negedge CLK);
            if (sec_tick === 1'b1) seen++;
            c++;
        end
        checks++;
        if (seen < n) begin
            errors++;
            $display("FAIL tick_wait got=%0d want=%0d", seen, n);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int addrs[9] = '{'h00, 'h21, 'h22, 'h23, 'h24, 'h25, 'h26, 'hF0, 'h50};
        int a, op;

        repeat (3) @(negedge CLK);
        checks++;
        if (ADout !== 8'h00 || ad_oe !== 1'b0 || sec_tick !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs got=%02h/%b/%b want=00/0/0", ADout, ad_oe, sec_tick);
        end
        reset = 1'b0;

        for (int i = 'h21; i <= 'h26; i++) read_reg(i);

        write_reg('h23, 'h15); read_reg('h23);
        write_reg('h50, 'hAA); read_reg('h50);
        write_reg('hF0, 'h55); read_reg('hF0);
        read_reg('h00);

        write_reg('h00, 'h01);
        write_reg('h21, 'h59); write_reg('h22, 'h59); write_reg('h23, 'h23);
        write_reg('h24, 'h31); write_reg('h25, 'h12); write_reg('h26, 'h99);
        write_reg('h00, 'h00);
        wait_ticks(1);
        write_reg('h00, 'h01);
        for (int i = 'h21; i <= 'h26; i++) read_reg(i);

        wait_ticks(5);
        read_reg('h21); read_reg('h00);
        write_reg('h00, 'h00);
        wait_ticks(1);
        read_reg('h21);

        write_reg('h00, 'h01);
        write_reg('h21, 'h59); write_reg('h22, 'h05);
        write_timed('h00, 'h00, 0);
        write_timed('h21, 'h30, TD - 1);
        write_timed('h00, 'h01, 0);
        read_reg('h21); read_reg('h22);
        write_reg('h21, 'h7A);
        write_timed('h00, 'h00, 0);
        wait_ticks(1);
        write_reg('h00, 'h01);
        read_reg('h21); read_reg('h22);

        addr_phase('h21);
        @(negedge CLK); ADin = 8'h44; wr_n = 1'b0; rd_n = 1'b0;
        @(negedge CLK);
        @(negedge CLK); wr_n = 1'b1; rd_n = 1'b1;
        @(negedge CLK); cs_n = 1'b1;
        read_reg('h21);
        write_reg('h21, 'h11, 1'b1);
        read_reg('h21);

        addr_phase('h23);
        @(negedge CLK); rd_n = 1'b0; rd_addr = 'h23; rd_active = 1'b1;
        @(negedge CLK);
        @(negedge CLK); reset = 1'b1; rd_active = 1'b0;
        @(negedge CLK); rd_n = 1'b1; cs_n = 1'b1;
        @(negedge CLK); reset = 1'b0;
        read_reg('h00);
        for (int i = 'h21; i <= 'h26; i++) read_reg(i);

        for (int k = 0; k < 60; k++) begin
            a = (($urandom_range(0, 3)) == 0) ? int'($urandom_range(0, 255)) : addrs[$urandom_range(0, 8)];
            op = $urandom_range(0, 2);
            if (op == 0) write_reg(a, $urandom_range(0, 255));
            else if (op == 1) read_reg(a);
            else write_reg(a, $urandom_range(0, 255), 1'b1);
            repeat ($urandom_range(0, 3)) @(negedge CLK);
        end
        for (int i = 'h21; i <= 'h26; i++) read_reg(i);

        repeat (3) @(negedge CLK);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL read_count got=%0d pending want=0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
